sram_rr_arbiter: RTL and testbench

//  Shares one word-addressed single-port SRAM between two requesters.

---
 rtl/sram_rr_arbiter.sv | 156 +++++++++++++++
 tb/tb_sram_rr_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rr_arbiter.sv
// Two-requester round-robin arbiter in front of one word-addressed single-port SRAM.
// Latency: request sampled at edge N, ACCESS for 1+WAIT_CYCLES cycles, ack pulse in the following cycle.
// Backpressure: a requester holds req (and stable addr/wdata/write) until its ack; the loser stays pending.
//
// Ports:
//   clk, rst                      clock and asynchronous active-high reset
//   m0_* / m1_*                   requester ports: req/write/addr/wdata in, ack/rdata out
//   sram_addr/wdata/wdata_en      registered SRAM drive (byte address passed through untouched)
//   sram_rdata                    combinational SRAM read data, captured on the last ACCESS cycle
//   grant_id                      requester currently or most recently granted
module sram_rr_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_CYCLES = 0    // 0..15, extra cycles the SRAM address is held
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_write,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_write,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_wdata_en,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  grant_id
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t                state_q, state_d;
  logic [3:0]            wait_q, wait_d;
  logic                  grant_q, grant_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wen_q, wen_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  logic                  win;
  logic                  win_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wait_q   <= 4'd0;
      grant_q  <= 1'b1;    // port 0 takes the first tie
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      grant_q  <= grant_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wen_q    <= wen_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    grant_d   = grant_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wen_d     = 1'b0;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    win       = 1'b0;
    win_write = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          // Tie goes to the port not granted last; a lone requester always wins.
          win       = (m0_req && m1_req) ? ~grant_q : m1_req;
          win_write = win ? m1_write : m0_write;
          grant_d   = win;
          write_d   = win_write;
          addr_d    = win ? m1_addr  : m0_addr;
          wdata_d   = win ? m1_wdata : m0_wdata;
          wait_d    = WAIT_INIT;
          // The strobe is a register, so it must be raised one edge ahead of the
          // last ACCESS cycle; with no wait states that is the first one.
          wen_d     = win_write && (WAIT_INIT == 4'd0);
          state_d   = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
          wen_d  = write_q && (wait_q == 4'd1);
        end else begin
          // Last ACCESS cycle: a write lands at this edge, a read is captured here.
          if (!write_q) begin
            if (grant_q) rdata1_d = sram_rdata;
            else         rdata0_d = sram_rdata;
          end
          if (grant_q) ack1_d = 1'b1;
          else         ack0_d = 1'b1;
          state_d = ST_ACK;
        end
      end

      ST_ACK: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign m0_ack        = ack0_q;
  assign m1_ack        = ack1_q;
  assign m0_rdata      = rdata0_q;
  assign m1_rdata      = rdata1_q;
  assign sram_addr     = addr_q;
  assign sram_wdata    = wdata_q;
  assign sram_wdata_en = wen_q;
  assign grant_id      = grant_q;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter: two instances (WAIT_CYCLES 0 and 3), each with its own SRAM model.
// A transaction-level scheduler predicts grants, ack cycles, strobes and read data.
// Requesters hold req until their predicted ack and may re-request immediately.
module tb_sram_rr_arbiter;

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
  } op_t;

  logic        clk;
  logic        rst     [2];
  logic        a_req   [2][2];
  logic        a_wr    [2][2];
  logic [31:0] a_addr  [2][2];
  logic [31:0] a_wdat  [2][2];
  logic        o_ack   [2][2];
  logic [31:0] o_rdata [2][2];
  logic [31:0] s_addr  [2];
  logic        s_wen   [2];
  logic [31:0] s_wdata [2];
  logic [31:0] s_rdata [2];
  logic        o_grant [2];

  bit [31:0] mem     [2][4096];   // the SRAMs the DUTs drive
  bit [31:0] ref_mem [2][4096];   // expected SRAM contents

  // scheduler / reference state, per instance
  int          cyc;
  int          free_at [2];
  bit          last_g  [2];
  bit          pv      [2];
  int          pe      [2];
  bit          pp      [2];
  bit          pw      [2];
  logic [31:0] pa      [2];
  logic [31:0] pd      [2];
  logic [31:0] e_saddr [2];
  logic [31:0] e_swdat [2];
  logic [31:0] e_rdata [2][2];

  // requester agents, index k*2+p
  op_t sq   [4][$];
  bit  busy [4];
  bit  rnd_en;

  // observations
  int checks, failures;
  int wen_cnt [2];
  int ack_cnt [2][2];
  int rep_cnt [2];
  int prev_ack [2];
  int lat_obs [2];
  int last_dec [2];
  int last_ack_c [2][2];
  int gap_err [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  sram_rr_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst[0]),
    .m0_req(a_req[0][0]), .m0_write(a_wr[0][0]), .m0_addr(a_addr[0][0]), .m0_wdata(a_wdat[0][0]),
    .m0_ack(o_ack[0][0]), .m0_rdata(o_rdata[0][0]),
    .m1_req(a_req[0][1]), .m1_write(a_wr[0][1]), .m1_addr(a_addr[0][1]), .m1_wdata(a_wdat[0][1]),
    .m1_ack(o_ack[0][1]), .m1_rdata(o_rdata[0][1]),
    .sram_addr(s_addr[0]), .sram_wdata_en(s_wen[0]), .sram_wdata(s_wdata[0]),
    .sram_rdata(s_rdata[0]), .grant_id(o_grant[0])
  );

  sram_rr_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst[1]),
    .m0_req(a_req[1][0]), .m0_write(a_wr[1][0]), .m0_addr(a_addr[1][0]), .m0_wdata(a_wdat[1][0]),
    .m0_ack(o_ack[1][0]), .m0_rdata(o_rdata[1][0]),
    .m1_req(a_req[1][1]), .m1_write(a_wr[1][1]), .m1_addr(a_addr[1][1]), .m1_wdata(a_wdat[1][1]),
    .m1_ack(o_ack[1][1]), .m1_rdata(o_rdata[1][1]),
    .sram_addr(s_addr[1]), .sram_wdata_en(s_wen[1]), .sram_wdata(s_wdata[1]),
    .sram_rdata(s_rdata[1]), .grant_id(o_grant[1])
  );

  assign s_rdata[0] = mem[0][s_addr[0][13:2]];
  assign s_rdata[1] = mem[1][s_addr[1][13:2]];

  always @(posedge clk) begin
    if (s_wen[0] === 1'b1) mem[0][s_addr[0][13:2]] <= s_wdata[0];
    if (s_wen[1] === 1'b1) mem[1][s_addr[1][13:2]] <= s_wdata[1];
  end

  function automatic int wv(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    free_at[k] = 0;
    last_g[k]  = 1'b1;
    pv[k]      = 1'b0;
    e_saddr[k] = '0;
    e_swdat[k] = '0;
    for (int p = 0; p < 2; p++) begin
      e_rdata[k][p] = '0;
      busy[k*2+p]   = 1'b0;
      a_req[k][p]   = 1'b0;
      a_wr[k][p]    = 1'b0;
      a_addr[k][p]  = '0;
      a_wdat[k][p]  = '0;
      sq[k*2+p].delete();
    end
  endtask

  task automatic q_op(input int i, input bit w, input logic [31:0] a, input logic [31:0] d);
    op_t o;
    o.w = w;
    o.a = a;
    o.d = d;
    sq[i].push_back(o);
  endtask

  // Compare instance k's outputs for the cycle that began at posedge 'cyc'.
  task automatic check_inst(input int k);
    logic ea [2];
    logic ew;
    ea[0] = 1'b0;
    ea[1] = 1'b0;
    ew    = 1'b0;
    if (pv[k]) begin
      if (pw[k] && cyc == pe[k] + wv(k)) ew = 1'b1;
      if (cyc == pe[k] + wv(k) + 1) begin
        ea[pp[k]] = 1'b1;
        if (pw[k]) ref_mem[k][pa[k][13:2]] = pd[k];
        else       e_rdata[k][pp[k]] = ref_mem[k][pa[k][13:2]];
        busy[k*2 + int'(pp[k])] = 1'b0;
        pv[k] = 1'b0;
      end
    end
    for (int p = 0; p < 2; p++) begin
      chk1($sformatf("i%0d_m%0d_ack", k, p), o_ack[k][p], ea[p]);
      chk32($sformatf("i%0d_m%0d_rdata", k, p), o_rdata[k][p], e_rdata[k][p]);
      if (o_ack[k][p] === 1'b1) begin
        ack_cnt[k][p]++;
        if (prev_ack[k] == p) rep_cnt[k]++;
        if (last_ack_c[k][p] >= 0 && cyc - last_ack_c[k][p] != 6) gap_err[k]++;
        last_ack_c[k][p] = cyc;
        prev_ack[k]      = p;
        lat_obs[k]       = cyc - last_dec[k];
      end
    end
    chk1($sformatf("i%0d_wen", k), s_wen[k], ew);
    chk32($sformatf("i%0d_saddr", k), s_addr[k], e_saddr[k]);
    chk32($sformatf("i%0d_swdata", k), s_wdata[k], e_swdat[k]);
    chk1($sformatf("i%0d_grant", k), o_grant[k], last_g[k]);
    if (s_wen[k] === 1'b1) wen_cnt[k]++;
  endtask

  // Update requesters, then predict what instance k decides at the next posedge.
  task automatic drive_inst(input int k);
    bit w;
    for (int p = 0; p < 2; p++) begin
      int  i;
      op_t o;
      bit  have;
      i    = k*2 + p;
      have = 1'b0;
      if (!busy[i] && rst[k] !== 1'b1) begin
        if (sq[i].size() > 0) begin
          o    = sq[i].pop_front();
          have = 1'b1;
        end else if (rnd_en && $urandom_range(0, 3) == 0) begin
          o.w  = 1'($urandom_range(0, 1));
          o.a  = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'h3);
          o.d  = $urandom;
          have = 1'b1;
        end
        if (have) begin
          busy[i]     = 1'b1;
          a_req[k][p] = 1'b1;
          a_wr[k][p]  = o.w;
          a_addr[k][p] = o.a;
          a_wdat[k][p] = o.d;
        end else begin
          a_req[k][p] = 1'b0;
        end
      end
    end
    if (rst[k] !== 1'b1 && !pv[k] && cyc + 1 >= free_at[k] && (a_req[k][0] || a_req[k][1])) begin
      if (a_req[k][0] && a_req[k][1]) w = !last_g[k];
      else                            w = a_req[k][1];
      pv[k]       = 1'b1;
      pe[k]       = cyc + 1;
      pp[k]       = w;
      pw[k]       = a_wr[k][w];
      pa[k]       = a_addr[k][w];
      pd[k]       = a_wdat[k][w];
      last_g[k]   = w;
      e_saddr[k]  = pa[k];
      e_swdat[k]  = pd[k];
      last_dec[k] = cyc + 1;
      free_at[k]  = cyc + 1 + wv(k) + 3;
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) check_inst(k);
      for (int k = 0; k < 2; k++) drive_inst(k);
    end
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < 4; i++) if (busy[i] || sq[i].size() > 0) return 1'b0;
    for (int k = 0; k < 2; k++) if (pv[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (!all_idle() && n < budget) begin
      run(1);
      n++;
    end
    chk_int("drain_done", int'(all_idle()), 1);
    run(3);
  endtask

  task automatic clear_obs(input int k);
    rep_cnt[k]  = 0;
    prev_ack[k] = -1;
    gap_err[k]  = 0;
    last_ack_c[k][0] = -1;
    last_ack_c[k][1] = -1;
  endtask

  initial begin
    int a0, a1, wc, n;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rnd_en   = 1'b0;
    rst[0]   = 1'b1;
    rst[1]   = 1'b1;
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      clear_obs(k);
      wen_cnt[k] = 0;
      lat_obs[k] = 0;
      last_dec[k] = 0;
      ack_cnt[k][0] = 0;
      ack_cnt[k][1] = 0;
    end

    // 1: reset held 105 ns; every cycle checks zeros, grant_id=1, no strobe
    run(10);
    #5;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    run(2);

    // 2: m0 write 0x10 then read 0x10 on the zero-wait instance
    wc = wen_cnt[0];
    q_op(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    q_op(0, 1'b0, 32'h0000_0010, 32'h0);
    drain(40);
    chk_int("t2_strobe_cycles", wen_cnt[0] - wc, 1);
    chk_int("t2_read_latency", lat_obs[0], 1);
    chk32("t2_m0_rdata", o_rdata[0][0], 32'hDEAD_BEEF);
    chk32("t2_m1_rdata", o_rdata[0][1], 32'h0);

    // 3: both ports request together and keep requesting
    clear_obs(0);
    a0 = ack_cnt[0][0];
    a1 = ack_cnt[0][1];
    for (int j = 0; j < 8; j++) begin
      q_op(0, 1'b1, 32'h0000_0040 + 32'(j*4), $urandom);
      q_op(1, 1'b0, 32'h0000_0040 + 32'(j*4), 32'h0);
    end
    drain(200);
    chk_int("t3_m0_acks", ack_cnt[0][0] - a0, 8);
    chk_int("t3_m1_acks", ack_cnt[0][1] - a1, 8);
    chk_int("t3_repeat_grants", rep_cnt[0], 0);
    chk_int("t3_ack_spacing", gap_err[0], 0);

    // 4: three wait states, m1 read of a preloaded word
    q_op(3, 1'b1, 32'h0000_0020, 32'h1234_5678);
    drain(40);
    wc = wen_cnt[1];
    q_op(3, 1'b0, 32'h0000_0020, 32'h0);
    drain(40);
    chk_int("t4_read_latency", lat_obs[1], 4);
    chk_int("t4_read_no_strobe", wen_cnt[1] - wc, 0);
    chk32("t4_m1_rdata", o_rdata[1][1], 32'h1234_5678);

    // 5: reset during the strobe cycle of an m0 write on the wait-state instance
    q_op(2, 1'b1, 32'h0000_0030, 32'hAAAA_5555);
    n = 0;
    while (!(pv[1] && cyc == pe[1] + wv(1)) && n < 50) begin
      run(1);
      n++;
    end
    chk_int("t5_reach_strobe", n < 50 ? 1 : 0, 1);
    chk1("t5_strobe_before_rst", s_wen[1], 1'b1);
    #1 rst[1] = 1'b1;
    #1;
    chk1("t5_strobe_async_drop", s_wen[1], 1'b0);
    chk1("t5_grant_after_rst", o_grant[1], 1'b1);
    chk32("t5_saddr_after_rst", s_addr[1], 32'h0);
    model_reset(1);
    run(2);
    rst[1] = 1'b0;
    q_op(2, 1'b0, 32'h0000_0030, 32'h0);
    drain(40);
    chk32("t5_read_after_rst", o_rdata[1][0], 32'h0);

    // 6: lone m1 requests on the zero-wait instance
    a0 = ack_cnt[0][0];
    a1 = ack_cnt[0][1];
    q_op(1, 1'b0, 32'h0000_0010, 32'h0);
    q_op(1, 1'b1, 32'h0000_0014, 32'h0BAD_F00D);
    q_op(1, 1'b0, 32'h0000_0014, 32'h0);
    drain(40);
    chk_int("t6_m1_acks", ack_cnt[0][1] - a1, 3);
    chk_int("t6_m0_acks", ack_cnt[0][0] - a0, 0);
    chk1("t6_grant", o_grant[0], 1'b1);
    chk32("t6_m1_rdata", o_rdata[0][1], 32'h0BAD_F00D);

    // random traffic on both instances
    rnd_en = 1'b1;
    run(1500);
    rnd_en = 1'b0;
    drain(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
